// File: rtl/testpattern_gen_pkg.sv
// Shared video parameters for the test pattern generator.
// Holds counter widths, sync bit positions, the LX1 active-window
// constants for PAL and NTSC, the pattern select encoding and the
// colour-bar table.
package testpattern_gen_pkg;

  localparam int HCNT_W = 10;
  localparam int VCNT_W = 9;
  localparam int SYNC_W = 4;

  // Sync nibble is {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
  localparam int SYNC_NVSYNC = 3;
  localparam int SYNC_NHSYNC = 1;

  localparam logic [VCNT_W-1:0] VSTART_NTSC_LX1 = 9'd18;
  localparam logic [VCNT_W-1:0] VSTOP_NTSC_LX1  = 9'd258;
  localparam logic [VCNT_W-1:0] VSTART_PAL_LX1  = 9'd24;
  localparam logic [VCNT_W-1:0] VSTOP_PAL_LX1   = 9'd312;
  localparam logic [HCNT_W-1:0] HSTART_NTSC     = 10'd90;
  localparam logic [HCNT_W-1:0] HSTOP_NTSC      = 10'd731;
  localparam logic [HCNT_W-1:0] HSTART_PAL      = 10'd100;
  localparam logic [HCNT_W-1:0] HSTOP_PAL       = 10'd741;

  typedef enum logic [1:0] {
    PAT_CHECKER = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_RAMP    = 2'd2,
    PAT_BORDER  = 2'd3
  } pattern_e;

  // {R,G,B} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                         3'b101, 3'b100, 3'b001, 3'b000};

endpackage

// File: rtl/tp_hvcnt.sv
// Sync edge detection and horizontal/vertical position counters.
// Ports:
//   clk_i    video clock
//   rst_n_i  synchronous active-low reset
//   valid_i  sample strobe; all state holds when low
//   sync_i   incoming sync nibble
//   sync_o   sync nibble registered on the last valid sample
//   hcnt_o   sample position in the line (saturating)
//   vcnt_o   line position in the frame (saturating)
//   vedge_o  falling nVSYNC on the current input sample (combinational)
module tp_hvcnt
  import testpattern_gen_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  input  logic [SYNC_W-1:0] sync_i,
  output logic [SYNC_W-1:0] sync_o,
  output logic [HCNT_W-1:0] hcnt_o,
  output logic [VCNT_W-1:0] vcnt_o,
  output logic              vedge_o
);

  logic [SYNC_W-1:0] sync_q;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic              hedge;

  always_comb begin
    hedge   = sync_q[SYNC_NHSYNC] & ~sync_i[SYNC_NHSYNC];
    vedge_o = sync_q[SYNC_NVSYNC] & ~sync_i[SYNC_NVSYNC];
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    if (hedge) begin
      hcnt_d = '0;
      if (vcnt_q != '1) vcnt_d = vcnt_q + 1'b1;
    end else if (hcnt_q != '1) begin
      hcnt_d = hcnt_q + 1'b1;
    end
    // frame start wins over the line increment
    if (vedge_o) vcnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (valid_i) begin
      sync_q <= sync_i;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign sync_o = sync_q;
  assign hcnt_o = hcnt_q;
  assign vcnt_o = vcnt_q;

endmodule

// File: rtl/testpattern_gen.sv
// Video test pattern generator. Replaces the colour part of a sync-only
// sample stream with a checkerboard, colour bars, grey ramp or border
// frame inside the PAL/NTSC active window. Sync passes with one sample
// of latency; the pattern choice is frozen at each frame start.
// Ports:
//   VCLK                video clock
//   nRST                synchronous active-low reset
//   palmode             1 = PAL window, 0 = NTSC window
//   pattern_sel         0 checker, 1 bars, 2 ramp, 3 border
//   vdata_sync_valid_i  input sample strobe
//   vdata_sync_i        {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
//   vdata_valid_o       strobe delayed by one clock
//   vdata_o             {sync, R, G, B}
module testpattern_gen
  import testpattern_gen_pkg::*;
#(
  parameter int COLOR_W    = 7,
  parameter int BAR_W      = 80,
  parameter int RAMP_SHIFT = 2
) (
  input  logic                   VCLK,
  input  logic                   nRST,
  input  logic                   palmode,
  input  logic [1:0]             pattern_sel,
  input  logic                   vdata_sync_valid_i,
  input  logic [SYNC_W-1:0]      vdata_sync_i,
  output logic                   vdata_valid_o,
  output logic [3*COLOR_W+3:0]   vdata_o
);

  localparam int BCNT_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int PRE_W  = (RAMP_SHIFT > 0) ? RAMP_SHIFT : 1;
  localparam logic [BCNT_W-1:0] BAR_LAST = BCNT_W'(BAR_W - 1);
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'((1 << RAMP_SHIFT) - 1);

  logic [SYNC_W-1:0]  sync;
  logic [HCNT_W-1:0]  hcnt;
  logic [VCNT_W-1:0]  vcnt;
  logic               vedge;

  logic               valid_q;
  pattern_e           sel_q;
  logic               chk_q, chk_d;
  logic [2:0]         bar_idx_q, bar_idx_d;
  logic [BCNT_W-1:0]  bar_cnt_q, bar_cnt_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [COLOR_W-1:0] grey_q, grey_d;
  logic [COLOR_W-1:0] r_q, g_q, b_q, r_d, g_d, b_d;

  logic [HCNT_W-1:0]  hstart, hstop;
  logic [VCNT_W-1:0]  vstart, vstop;
  logic               active, border;

  tp_hvcnt u_hvcnt (
    .clk_i   (VCLK),
    .rst_n_i (nRST),
    .valid_i (vdata_sync_valid_i),
    .sync_i  (vdata_sync_i),
    .sync_o  (sync),
    .hcnt_o  (hcnt),
    .vcnt_o  (vcnt),
    .vedge_o (vedge)
  );

  always_comb begin
    hstart = palmode ? HSTART_PAL     : HSTART_NTSC;
    hstop  = palmode ? HSTOP_PAL      : HSTOP_NTSC;
    vstart = palmode ? VSTART_PAL_LX1 : VSTART_NTSC_LX1;
    vstop  = palmode ? VSTOP_PAL_LX1  : VSTOP_NTSC_LX1;
    active = (vcnt >= vstart) && (vcnt < vstop) && (hcnt > hstart) && (hcnt < hstop);
    border = (vcnt == vstart) || (vcnt == vstop - 9'd1) ||
             (hcnt == hstart + 10'd1) || (hcnt == hstop - 10'd1);

    chk_d     = chk_q;
    bar_idx_d = bar_idx_q;
    bar_cnt_d = bar_cnt_q;
    pre_d     = pre_q;
    grey_d    = grey_q;
    r_d       = '0;
    g_d       = '0;
    b_d       = '0;

    // Pattern state is re-armed just before the first active sample of
    // every line, so the line's first pixel shows the initial value.
    if (hcnt == hstart) begin
      chk_d     = vcnt[0];
      bar_idx_d = '0;
      bar_cnt_d = '0;
      pre_d     = '0;
      grey_d    = '0;
    end else if (active) begin
      chk_d = ~chk_q;
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 1'b1;
      end
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        if (grey_q != '1) grey_d = grey_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    if (active) begin
      unique case (sel_q)
        PAT_CHECKER: begin
          r_d = {COLOR_W{chk_q}};
          g_d = {COLOR_W{chk_q}};
          b_d = {COLOR_W{chk_q}};
        end
        PAT_BARS: begin
          r_d = {COLOR_W{BAR_RGB[bar_idx_q][2]}};
          g_d = {COLOR_W{BAR_RGB[bar_idx_q][1]}};
          b_d = {COLOR_W{BAR_RGB[bar_idx_q][0]}};
        end
        PAT_RAMP: begin
          r_d = grey_q;
          g_d = grey_q;
          b_d = grey_q;
        end
        PAT_BORDER: begin
          r_d = {COLOR_W{border}};
          g_d = {COLOR_W{border}};
          b_d = {COLOR_W{border}};
        end
      endcase
    end
  end

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      valid_q   <= 1'b0;
      sel_q     <= PAT_CHECKER;
      chk_q     <= 1'b0;
      bar_idx_q <= '0;
      bar_cnt_q <= '0;
      pre_q     <= '0;
      grey_q    <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      valid_q <= vdata_sync_valid_i;
      if (vdata_sync_valid_i) begin
        if (vedge) sel_q <= pattern_e'(pattern_sel);
        chk_q     <= chk_d;
        bar_idx_q <= bar_idx_d;
        bar_cnt_q <= bar_cnt_d;
        pre_q     <= pre_d;
        grey_q    <= grey_d;
        r_q       <= r_d;
        g_q       <= g_d;
        b_q       <= b_d;
      end
    end
  end

  assign vdata_valid_o = valid_q;
  assign vdata_o       = {sync, r_q, g_q, b_q};

endmodule

// File: tb/tb_testpattern_gen.sv
// Randomized bench for testpattern_gen with a position-based reference model.
module tb_testpattern_gen;

  localparam int CW = 7;
  localparam int BW = 80;
  localparam int RS = 2;
  localparam int DW = 3*CW + 4;

  localparam int HS_N = 90,  HP_N = 731, VS_N = 18, VP_N = 258;
  localparam int HS_P = 100, HP_P = 741, VS_P = 24, VP_P = 312;

  logic          VCLK = 1'b0;
  logic          nRST = 1'b0;
  logic          palmode = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic          vdata_sync_valid_i = 1'b0;
  logic [3:0]    vdata_sync_i = 4'hF;
  logic          vdata_valid_o;
  logic [DW-1:0] vdata_o;

  int n_cmp = 0;
  int n_err = 0;
  int gap_lo = 0;
  int gap_hi = 0;
  bit rand_sel = 1'b0;

  // reference model state: position, frame selection, active samples since hstart
  int         m_h, m_v, m_sel, m_n, m_v0;
  logic [3:0] m_sync;
  logic       m_valid;
  logic [DW-1:0] m_out;

  // {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black
  int bar_rgb [8] = '{7, 6, 3, 2, 5, 4, 1, 0};

  testpattern_gen dut (
    .VCLK               (VCLK),
    .nRST               (nRST),
    .palmode            (palmode),
    .pattern_sel        (pattern_sel),
    .vdata_sync_valid_i (vdata_sync_valid_i),
    .vdata_sync_i       (vdata_sync_i),
    .vdata_valid_o      (vdata_valid_o),
    .vdata_o            (vdata_o)
  );

  always #5 VCLK = ~VCLK;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3*CW-1:0] exp_colour(input int sel, input int n, input int v0,
                                                 input int h, input int v, input int hs,
                                                 input int hp, input int vs, input int vp);
    logic [CW-1:0] one, r, g, b;
    int idx, gi;
    one = '1;
    r = '0; g = '0; b = '0;
    case (sel)
      0: if (((v0 + n) % 2) == 1) begin r = one; g = one; b = one; end
      1: begin
        idx = n / BW;
        if (idx > 7) idx = 7;
        if ((bar_rgb[idx] & 4) != 0) r = one;
        if ((bar_rgb[idx] & 2) != 0) g = one;
        if ((bar_rgb[idx] & 1) != 0) b = one;
      end
      2: begin
        gi = n >> RS;
        if (gi > (1 << CW) - 1) gi = (1 << CW) - 1;
        r = CW'(gi); g = CW'(gi); b = CW'(gi);
      end
      default:
        if (v == vs || v == vp - 1 || h == hs + 1 || h == hp - 1) begin
          r = one; g = one; b = one;
        end
    endcase
    return {r, g, b};
  endfunction

  task automatic model_step(input logic rst_b, input logic vld, input logic [3:0] s,
                            input logic [1:0] psel, input logic pal);
    int hs, hp, vs, vp;
    bit act, he, ve;
    logic [3*CW-1:0] c;
    if (!rst_b) begin
      m_h = 0; m_v = 0; m_sel = 0; m_n = 0; m_v0 = 0;
      m_sync = '0; m_valid = 1'b0; m_out = '0;
      return;
    end
    m_valid = vld;
    if (!vld) return;
    hs = pal ? HS_P : HS_N;
    hp = pal ? HP_P : HP_N;
    vs = pal ? VS_P : VS_N;
    vp = pal ? VP_P : VP_N;
    act = (m_v >= vs) && (m_v < vp) && (m_h > hs) && (m_h < hp);
    c = act ? exp_colour(m_sel, m_n, m_v0, m_h, m_v, hs, hp, vs, vp) : '0;
    if (m_h == hs) begin
      m_n = 0;
      m_v0 = m_v;
    end else if (act) begin
      m_n++;
    end
    he = m_sync[1] && !s[1];
    ve = m_sync[3] && !s[3];
    if (ve) m_sel = int'(psel);
    if (he) m_h = 0; else if (m_h < 1023) m_h++;
    if (ve) m_v = 0; else if (he && m_v < 511) m_v++;
    m_sync = s;
    m_out = {s, c};
  endtask

  task automatic cyc(input logic vld, input logic [3:0] s);
    vdata_sync_valid_i = vld;
    vdata_sync_i = s;
    @(posedge VCLK);
    model_step(nRST, vld, s, pattern_sel, palmode);
    #1;
    check("valid", {31'd0, vdata_valid_o}, {31'd0, m_valid});
    check("vdata", 32'(vdata_o), 32'(m_out));
  endtask

  task automatic smp(input logic [3:0] s);
    int g;
    g = $urandom_range(gap_hi, gap_lo);
    repeat (g) cyc(1'b0, 4'($urandom));
    cyc(1'b1, s);
  endtask

  task automatic line(input int len, input bit vlow);
    for (int i = 0; i < len; i++)
      smp({~vlow, 1'($urandom), (i == 0) ? 1'b0 : 1'b1, 1'($urandom)});
  endtask

  task automatic frame(input bit pal, input bit to_end, input bit long_line);
    int vs, vp, nl, len;
    bit full;
    vs = pal ? VS_P : VS_N;
    vp = pal ? VP_P : VP_N;
    nl = to_end ? vp + 1 : vs + 3;
    palmode = pal;
    smp(4'hF);
    for (int l = 0; l < nl; l++) begin
      if (rand_sel && l > 0 && $urandom_range(3, 0) == 0) pattern_sel = 2'($urandom);
      full = (l == vs) || (l == vs + 1) || (l == vs + 2) || (l == vp - 1) || (l == vp);
      len = full ? $urandom_range(790, 745) : 8;
      if (long_line && l == vs + 1) len = 1200;
      line(len, l == 0);
    end
  endtask

  initial begin
    nRST = 1'b0;
    repeat (3) cyc(1'b1, 4'($urandom));
    nRST = 1'b1;

    // NTSC checkerboard, strobe on every 4th clock
    gap_lo = 3; gap_hi = 3; rand_sel = 1'b0; pattern_sel = 2'd0;
    frame(1'b0, 1'b0, 1'b0);

    // each pattern for a full frame, selection wandering mid-frame
    gap_lo = 0; gap_hi = 1; rand_sel = 1'b1;
    for (int f = 0; f < 4; f++) begin
      pattern_sel = 2'(f);
      frame(1'($urandom), 1'b1, f == 0);
    end

    // vertical counter saturation: a wrap would land back in the window
    gap_lo = 0; gap_hi = 0; rand_sel = 1'b0; palmode = 1'b0; pattern_sel = 2'd3;
    smp(4'hF);
    line(8, 1'b1);
    for (int l = 0; l < 530; l++) line(4, 1'b0);
    line(780, 1'b0);

    // reset in the middle of an active bars line
    pattern_sel = 2'd1;
    frame(1'b0, 1'b0, 1'b0);
    line(200, 1'b0);
    nRST = 1'b0;
    cyc(1'b1, 4'hF);
    nRST = 1'b1;
    for (int i = 0; i < 600; i++) smp(4'hF);
    line(780, 1'b0);
    line(780, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
